pwm_breath_ctrl: RTL

//  Duty-cycle sequencer for the 8-bit PWM LED core. Debounces the five board keys
//  and turns each clean press into one duty edit (manual mode). It can also run an

---
 rtl/pwm_ctrl_pkg.sv | 30 +++
 rtl/pwm_breath_ctrl_if.sv | 13 +
 rtl/key_debounce.sv | 43 ++++
 rtl/pwm_breath_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM breathing duty sequencer.
package pwm_ctrl_pkg;

  typedef enum logic [2:0] {
    MANUAL  = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  localparam logic [7:0] DUTY_MAX    = 8'd255;
  localparam logic [7:0] DUTY_HALF   = 8'd127;
  localparam logic [7:0] STEP_FINE   = 8'd1;
  localparam logic [7:0] STEP_COARSE = 8'd10;

  // 9-bit add/subtract; the carry/borrow bit selects the clamp value.
  function automatic logic [7:0] sat_step(input logic [7:0] d, input logic [7:0] step,
                                          input logic up);
    logic [8:0] s;
    if (up) begin
      s = {1'b0, d} + {1'b0, step};
      sat_step = s[8] ? DUTY_MAX : s[7:0];
    end else begin
      s = {1'b0, d} - {1'b0, step};
      sat_step = s[8] ? 8'd0 : s[7:0];
    end
  endfunction

endpackage

// File: rtl/pwm_breath_ctrl_if.sv
// Key / PWM-core side signals of the duty sequencer.
interface pwm_breath_ctrl_if;
  logic [4:0] key_raw;
  logic       pwm_period_end;
  logic [7:0] duty;
  logic       duty_upd;
  logic [2:0] mode;

  modport master (output key_raw, output pwm_period_end,
                  input duty, input duty_upd, input mode);
  modport slave  (input key_raw, input pwm_period_end,
                  output duty, output duty_upd, output mode);
endinterface

// File: rtl/key_debounce.sv
// One active-low key: 2-FF synchroniser, stability counter, 1-cycle press pulse.
module key_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic press
);
  logic        sync1, sync2;
  logic        level, level_q;
  logic [19:0] cnt;
  logic        sample;

  assign sample = ~sync2;

  // level is the debounced pressed state; press fires one cycle after it rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= key_raw;
      sync2   <= sync1;
      level_q <= level;
      press   <= level & ~level_q;
      if (sample != level) begin
        if (cnt == DEBOUNCE_CYCLES - 20'd1) begin
          level <= sample;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 20'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/pwm_breath_ctrl.sv
// Duty-cycle sequencer: manual key edits or autonomous breathing ramp.
//  state   | meaning
//  MANUAL  | keys edit duty with saturation
//  UP      | ramp +1 every BREATH_DIV period ends
//  HOLD_HI | hold 255 for PAUSE_PERIODS period ends
//  DOWN    | ramp -1 every BREATH_DIV period ends
//  HOLD_LO | hold 0 for PAUSE_PERIODS period ends
module pwm_breath_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter logic [7:0]  BREATH_DIV      = 8'd2,
  parameter logic [7:0]  PAUSE_PERIODS   = 8'd64
) (
  input logic              clk,
  input logic              rst,
  pwm_breath_ctrl_if.slave bus
);
  logic [4:0] ev;
  logic [4:0] sel;
  state_t     state, state_n;
  logic [7:0] duty_r, duty_n, div, div_n, pause, pause_n;
  logic       upd_r;

  for (genvar i = 0; i < 5; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk(clk), .rst(rst), .key_raw(bus.key_raw[i]), .press(ev[i])
    );
  end

  always_comb begin
    sel = 5'b0;
    if      (ev[4]) sel = 5'b10000;
    else if (ev[3]) sel = 5'b01000;
    else if (ev[2]) sel = 5'b00100;
    else if (ev[1]) sel = 5'b00010;
    else if (ev[0]) sel = 5'b00001;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MANUAL;
      duty_r <= '0;
      div    <= '0;
      pause  <= '0;
      upd_r  <= 1'b0;
    end else begin
      state  <= state_n;
      duty_r <= duty_n;
      div    <= div_n;
      pause  <= pause_n;
      upd_r  <= (duty_n != duty_r);
    end
  end

  always_comb begin
    state_n = state;
    duty_n  = duty_r;
    div_n   = div;
    pause_n = pause;
    case (state)
      MANUAL: begin
        if      (sel[4]) duty_n = sat_step(duty_r, STEP_COARSE, 1'b1);
        else if (sel[3]) duty_n = sat_step(duty_r, STEP_COARSE, 1'b0);
        else if (sel[2]) duty_n = sat_step(duty_r, STEP_FINE, 1'b1);
        else if (sel[1]) duty_n = sat_step(duty_r, STEP_FINE, 1'b0);
        else if (sel[0]) begin
          state_n = UP;
          div_n   = '0;
          pause_n = '0;
        end
      end
      default: begin
        // A mode event takes precedence over a coincident period end.
        if (sel[0]) begin
          state_n = MANUAL;
          duty_n  = DUTY_HALF;
          div_n   = '0;
          pause_n = '0;
        end else if (bus.pwm_period_end) begin
          case (state)
            UP: begin
              if (duty_r == DUTY_MAX) begin
                state_n = HOLD_HI;
                div_n   = '0;
              end else if (div == BREATH_DIV - 8'd1) begin
                div_n  = '0;
                duty_n = duty_r + STEP_FINE;
                if (duty_r == DUTY_MAX - STEP_FINE) state_n = HOLD_HI;
              end else begin
                div_n = div + 8'd1;
              end
            end
            HOLD_HI: begin
              if (pause == PAUSE_PERIODS - 8'd1) begin
                state_n = DOWN;
                pause_n = '0;
              end else begin
                pause_n = pause + 8'd1;
              end
            end
            DOWN: begin
              if (duty_r == 8'd0) begin
                state_n = HOLD_LO;
                div_n   = '0;
              end else if (div == BREATH_DIV - 8'd1) begin
                div_n  = '0;
                duty_n = duty_r - STEP_FINE;
                if (duty_r == STEP_FINE) state_n = HOLD_LO;
              end else begin
                div_n = div + 8'd1;
              end
            end
            HOLD_LO: begin
              if (pause == PAUSE_PERIODS - 8'd1) begin
                state_n = UP;
                pause_n = '0;
              end else begin
                pause_n = pause + 8'd1;
              end
            end
            default: state_n = MANUAL;
          endcase
        end
      end
    endcase
  end

  assign bus.duty     = duty_r;
  assign bus.duty_upd = upd_r;
  assign bus.mode     = state;
endmodule
